// File: rtl/mcs_cmd_handshake.sv
// Debounced push-button to MicroBlaze MCS command handshake: each press captures the
// switch bank and holds it on the GPIO inputs until firmware acknowledges it.
module mcs_cmd_handshake #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned SW_WIDTH        = 8,
   parameter int unsigned ACK_TIMEOUT     = 100000000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                btn_raw,
   input  logic [SW_WIDTH-1:0] sw_raw,
   input  logic                mcs_ack,
   input  logic                clr_flags,
   output logic                cmd_valid,
   output logic [SW_WIDTH-1:0] cmd_data,
   output logic                busy,
   output logic                overrun,
   output logic                timeout
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TO_W = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam bit              TO_EN   = (ACK_TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PENDING      = 2'd1,
      ST_WAIT_ACK_LOW = 2'd2
   } state_e;

   logic                btn_meta_q, btn_s_q;
   logic [SW_WIDTH-1:0] sw_meta_q, sw_s_q;
   logic                ack_meta_q, ack_s_q;

   logic [DB_W-1:0]     db_cnt_d, db_cnt_q;
   logic                db_btn_d, db_btn_q;
   logic                db_prev_q;
   logic                press;

   state_e              state_d, state_q;
   logic                busy_d, busy_q;
   logic                cmd_valid_d, cmd_valid_q;
   logic [SW_WIDTH-1:0] cmd_data_d, cmd_data_q;
   logic [TO_W-1:0]     to_cnt_d, to_cnt_q;
   logic                overrun_d, overrun_q;
   logic                timeout_d, timeout_q;

   // Two-flop synchronizers for every asynchronous input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_meta_q <= 1'b0;
         btn_s_q    <= 1'b0;
         sw_meta_q  <= '0;
         sw_s_q     <= '0;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so each stage takes the value its predecessor held before this edge.
         btn_meta_q <= btn_raw;
         btn_s_q    <= btn_meta_q;
         sw_meta_q  <= sw_raw;
         sw_s_q     <= sw_meta_q;
         ack_meta_q <= mcs_ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      db_cnt_d = '0;
      db_btn_d = db_btn_q;
      if (btn_s_q != db_btn_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_btn_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   // Only a debounced rising level is a press; releases are silent.
   assign press = db_btn_q & ~db_prev_q;

   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_data_d  = cmd_data_q;
      to_cnt_d    = to_cnt_q;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;

      if (clr_flags) begin
         overrun_d = 1'b0;
         timeout_d = 1'b0;
      end
      if (press && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (press) begin
               cmd_data_d  = sw_s_q;
               cmd_valid_d = 1'b1;
               to_cnt_d    = '0;
               state_d     = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (ack_s_q) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_WAIT_ACK_LOW;
            end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
               cmd_valid_d = 1'b0;
               timeout_d   = 1'b1;
               state_d     = ST_WAIT_ACK_LOW;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_WAIT_ACK_LOW: begin
            if (!ack_s_q) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cmd_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q    <= '0;
         db_btn_q    <= 1'b0;
         db_prev_q   <= 1'b0;
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         to_cnt_q    <= '0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         db_cnt_q    <= db_cnt_d;
         db_btn_q    <= db_btn_d;
         db_prev_q   <= db_btn_q;
         state_q     <= state_d;
         busy_q      <= busy_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_data_q  <= cmd_data_d;
         to_cnt_q    <= to_cnt_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_data  = cmd_data_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_mcs_cmd_handshake.sv
// Bench for mcs_cmd_handshake: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-derived edge counts and data values.
module tb_mcs_cmd_handshake;

   localparam int DC = 4;
   localparam int TO = 20;
   localparam int SW = 8;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b1;
   logic          btn_raw, mcs_ack, clr_flags;
   logic [SW-1:0] sw_raw;
   logic          cmd_valid, busy, overrun, timeout;
   logic [SW-1:0] cmd_data;

   int total = 0;
   int bad   = 0;

   mcs_cmd_handshake #(
      .DEBOUNCE_CYCLES(DC),
      .SW_WIDTH       (SW),
      .ACK_TIMEOUT    (TO)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_raw),
      .sw_raw   (sw_raw),
      .mcs_ack  (mcs_ack),
      .clr_flags(clr_flags),
      .cmd_valid(cmd_valid),
      .cmd_data (cmd_data),
      .busy     (busy),
      .overrun  (overrun),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: input delay lines, a run-length debouncer and a mode that
   // remembers the cycle it entered PENDING, so timeout is a cycle-count difference.
   typedef enum {M_IDLE, M_PEND, M_WAIT} mode_t;
   mode_t         m_mode;
   logic          m_b1, m_bs, m_a1, m_as;
   logic [SW-1:0] m_s1, m_ss;
   logic          m_lvl, m_lvl_prev;
   int            m_run, m_cyc, m_pend_start;
   logic          m_valid, m_ovr, m_to;
   logic [SW-1:0] m_data;

   task automatic model_reset();
      m_mode = M_IDLE;
      m_b1 = 0; m_bs = 0; m_a1 = 0; m_as = 0; m_s1 = '0; m_ss = '0;
      m_lvl = 0; m_lvl_prev = 0; m_run = 0; m_cyc = 0; m_pend_start = 0;
      m_valid = 0; m_ovr = 0; m_to = 0; m_data = '0;
   endtask

   task automatic model_step();
      logic pressed, acked, ovr_set, to_set;
      m_cyc++;
      pressed = m_lvl && !m_lvl_prev;
      acked   = m_as;
      ovr_set = pressed && (m_mode != M_IDLE);
      to_set  = 0;
      case (m_mode)
         M_IDLE: if (pressed) begin
            m_data = m_ss; m_valid = 1; m_pend_start = m_cyc; m_mode = M_PEND;
         end
         M_PEND: if (acked) begin
            m_valid = 0; m_mode = M_WAIT;
         end else if (m_cyc - m_pend_start == TO) begin
            m_valid = 0; to_set = 1; m_mode = M_WAIT;
         end
         M_WAIT: if (!acked) m_mode = M_IDLE;
      endcase
      m_ovr = ovr_set ? 1'b1 : (clr_flags ? 1'b0 : m_ovr);
      m_to  = to_set  ? 1'b1 : (clr_flags ? 1'b0 : m_to);
      m_lvl_prev = m_lvl;
      if (m_bs == m_lvl) m_run = 0;
      else begin
         m_run++;
         if (m_run == DC) begin m_lvl = m_bs; m_run = 0; end
      end
      m_bs = m_b1; m_b1 = btn_raw;
      m_ss = m_s1; m_s1 = sw_raw;
      m_as = m_a1; m_a1 = mcs_ack;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("cmp_valid",   cmd_valid, m_valid);
         check("cmp_data",    cmd_data,  m_data);
         check("cmp_busy",    busy,      (m_mode != M_IDLE));
         check("cmp_overrun", overrun,   m_ovr);
         check("cmp_timeout", timeout,   m_to);
      end
   end

   // Counts posedges until the selected output (0: cmd_valid, 1: busy) equals want.
   task automatic wait_for(input int sel, input logic want, input int limit, output int n);
      logic v;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         v = (sel == 0) ? cmd_valid : busy;
      end while ((v !== want) && (n < limit));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n;
      logic saw;
      reset_n = 0; btn_raw = 0; sw_raw = '0; mcs_ack = 0; clr_flags = 0;
      @(negedge clk);
      check("rst_valid", cmd_valid, 0);
      check("rst_data",  cmd_data,  0);
      check("rst_busy",  busy,      0);
      check("rst_ovr",   overrun,   0);
      check("rst_to",    timeout,   0);
      repeat (2) @(negedge clk);
      reset_n = 1;
      repeat (2) @(negedge clk);

      // Basic handshake
      sw_raw = 8'hA5; btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("basic_rise_edge", n, 7);
      check("basic_data", cmd_data, 8'hA5);
      repeat (5) @(negedge clk);
      mcs_ack = 1;
      wait_for(0, 0, 40, n);
      check("basic_fall_edge", n, 3);
      check("basic_busy_wait", busy, 1);
      @(negedge clk);
      mcs_ack = 0;
      wait_for(1, 0, 40, n);
      check("basic_idle_edge", n, 3);
      check("basic_ovr", overrun, 0);
      check("basic_to", timeout, 0);
      @(negedge clk);
      btn_raw = 0;
      repeat (10) @(negedge clk);

      // Bounce rejection
      saw = 0;
      for (int i = 0; i < 30; i++) begin
         btn_raw = i[1];
         @(negedge clk);
         if (busy || cmd_valid) saw = 1;
      end
      btn_raw = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy || cmd_valid) saw = 1;
      end
      check("bounce_no_cmd", saw, 0);

      // Timeout
      sw_raw = 8'h42; btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("to_rise_edge", n, 7);
      wait_for(0, 0, 60, n);
      check("to_fall_edge", n, 20);
      check("to_flag", timeout, 1);
      check("to_busy_held", busy, 1);
      wait_for(1, 0, 10, n);
      check("to_idle", busy, 0);
      @(negedge clk);
      clr_flags = 1;
      @(negedge clk);
      clr_flags = 0;
      check("to_clr", timeout, 0);
      btn_raw = 0;
      repeat (10) @(negedge clk);

      // Overrun
      sw_raw = 8'h5A; btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("ovr_first_data", cmd_data, 8'h5A);
      @(negedge clk);
      btn_raw = 0;
      repeat (7) @(negedge clk);
      sw_raw = 8'h3C; btn_raw = 1;
      repeat (8) @(negedge clk);
      check("ovr_flag", overrun, 1);
      check("ovr_data_kept", cmd_data, 8'h5A);
      check("ovr_still_pend", cmd_valid, 1);
      mcs_ack = 1;
      wait_for(0, 0, 10, n);
      check("ovr_ack_fall", n, 3);
      @(negedge clk);
      mcs_ack = 0;
      wait_for(1, 0, 10, n);
      @(negedge clk);
      btn_raw = 0;
      repeat (8) @(negedge clk);
      btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("ovr_third_edge", n, 7);
      check("ovr_third_data", cmd_data, 8'h3C);
      repeat (2) @(negedge clk);
      mcs_ack = 1;
      wait_for(0, 0, 10, n);
      @(negedge clk);
      mcs_ack = 0;
      wait_for(1, 0, 10, n);
      @(negedge clk);
      btn_raw = 0; clr_flags = 1;
      @(negedge clk);
      clr_flags = 0;
      check("ovr_clr", overrun, 0);
      repeat (8) @(negedge clk);

      // Switch change while pending
      sw_raw = 8'h01; btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("sw_first_data", cmd_data, 8'h01);
      @(negedge clk);
      sw_raw = 8'hFF;
      repeat (6) @(negedge clk);
      check("sw_hold_pend", cmd_data, 8'h01);
      mcs_ack = 1;
      wait_for(0, 0, 10, n);
      check("sw_hold_wait", cmd_data, 8'h01);
      @(negedge clk);
      mcs_ack = 0;
      wait_for(1, 0, 10, n);
      check("sw_hold_idle", cmd_data, 8'h01);
      @(negedge clk);
      btn_raw = 0;
      repeat (8) @(negedge clk);

      // Reset mid-operation
      sw_raw = 8'h77; btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("mrst_pend", cmd_valid, 1);
      repeat (3) @(negedge clk);
      #2;
      reset_n = 0;
      #1;
      check("mrst_valid", cmd_valid, 0);
      check("mrst_data",  cmd_data,  0);
      check("mrst_busy",  busy,      0);
      check("mrst_ovr",   overrun,   0);
      check("mrst_to",    timeout,   0);
      repeat (2) @(negedge clk);
      reset_n = 1;
      saw = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (busy || cmd_valid) saw = 1;
      end
      btn_raw = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (busy || cmd_valid) saw = 1;
      end
      check("mrst_no_cmd", saw, 0);
      @(negedge clk);
      btn_raw = 1;
      wait_for(0, 1, 40, n);
      check("mrst_repress_edge", n, 7);
      check("mrst_repress_data", cmd_data, 8'h77);
      @(negedge clk);
      mcs_ack = 1;
      wait_for(0, 0, 10, n);
      @(negedge clk);
      mcs_ack = 0;
      wait_for(1, 0, 10, n);
      check("end_idle", busy, 0);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
